change_dispenser_ctrl: RTL
==========================

Name: change_dispenser_ctrl

Overview:
Sequences physical change return after a vend. Takes the change amount produced by the vending FSM on its completion pulse and greedily ejects coins from three denomination tubes. Each coin goes through a 4-phase req/ack handshake with the coin-ejector driver. Tracks per-tube inventory, including refills, and reports exact or short change.

Parameters:
DENOM_HI, 5, value of high tube coin
DENOM_MID, 2, value of mid tube coin
DENOM_LO, 1, value of low tube coin
TUBE_DEPTH, 15, max coins per tube (saturation limit, fits 4 bits)
INIT_COUNT, 8, per-tube count loaded at reset
ACK_TIMEOUT, 100000000, cycles allowed per handshake phase (1 s at 100MHz)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin dispensing amount
amount  in  8  change value to return, sampled on accepted start
eject_ack  in  1  ejector acknowledge (4-phase)
refill_pulse  in  1  one-cycle: add one coin to tube refill_sel
refill_sel  in  2  0=HI 1=MID 2=LO 3=ignored
eject_req  out  1  ejector request
eject_sel  out  2  tube being ejected (0/1/2)
busy  out  1  high whenever not IDLE
done  out  1  one-cycle completion pulse
short_flag  out  1  change could not be made exactly; held until next accepted start
remaining  out  8  value still owed
count_hi, count_mid, count_lo  out  4 each  tube inventories
fault  out  1  handshake timeout (macro only)

Behaviour:
- Reset values: outputs 0 except counts=INIT_COUNT; state IDLE.
- IDLE:
  - start latches remaining<=amount, clears short_flag, goes to SELECT.
  - start in any other state is ignored, with no latch.
- SELECT: one cycle, combinational pick of the largest denomination d with d<=remaining and count_d>0.
  - remaining==0 -> DONE.
  - No eligible tube -> short_flag<=1, go to DONE.
  - Otherwise latch eject_sel and go to EJECT.
- EJECT: eject_req=1 and eject_sel stable.
  - On eject_ack=1: remaining-=d, count_d-=1, go to RELEASE.
- RELEASE: eject_req=0; wait for eject_ack=0, then go to SELECT.
- DONE: done=1 for one cycle, then IDLE. busy falls in the same cycle DONE exits.
- Latency: amount=0 gives done 2 cycles after start. Each coin costs at least 3 cycles plus ack delays.
- Handshake rule: eject_req never deasserts before ack; eject_sel never changes while req or ack is high.
- Refill is accepted in any state:
  - Count saturates at TUBE_DEPTH.
  - refill_sel=3 is a no-op.
  - Refill and decrement of the same tube in the same cycle: net count unchanged.
  - A refill during SELECT is visible from the next SELECT.
- remaining never underflows; 8-bit arithmetic throughout, denominations zero-extended.
- Reset mid-handshake drops eject_req immediately, asynchronously.

Optional Feature:
CHANGE_ACK_TIMEOUT_EN
- Defined:
  - A 32-bit counter runs in EJECT and RELEASE and clears on each phase entry.
  - Reaching ACK_TIMEOUT-1 goes to state FAULT: fault=1, eject_req=0, busy=1.
  - FAULT exits only on reset.
- Undefined: no counter, fault tied 0, handshake waits indefinitely.

Decomposition:
- Shared package vend_pkg holds:
  - state encodings IDLE/SELECT/EJECT/RELEASE/DONE/FAULT (3 bits);
  - tube index constants TUBE_HI=0, TUBE_MID=1, TUBE_LO=2;
  - the common 8-bit money width.
- One natural sub-module, coin_tube_counter: a 4-bit saturating up/down counter with simultaneous inc/dec. It is instantiated three times.

Test Plan:
- Full tubes, start amount=8, ack after 2 cycles -> eject_sel sequence 0,1,2; remaining 8,3,1,0; counts 7/7/7; done pulse; short_flag=0.
- count_mid=0, amount=4 -> four ejects on sel=2; count_lo 8->4; short_flag=0.
- Counts hi=0 mid=1 lo=0, amount=3 -> one eject sel=1; remaining=1; short_flag=1 with done.
- amount=0 -> no eject_req; done exactly 2 cycles after start. Second start while busy -> ignored, remaining unchanged.
- count_lo=15, refill_pulse sel=2 -> stays 15. Refill sel=1 in the same cycle as a MID eject ack -> count_mid unchanged.
- With CHANGE_ACK_TIMEOUT_EN, ACK_TIMEOUT=20, ack never returns -> fault=1 at cycle 20 of EJECT, eject_req=0. rst_n low -> all outputs reset, counts=INIT_COUNT.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vending change path: controller state encoding, tube
// indices and the common money width.
package vend_pkg;

  localparam int MONEY_W = 8;

  typedef logic [MONEY_W-1:0] money_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    EJECT   = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [1:0] TUBE_HI  = 2'd0;
  localparam logic [1:0] TUBE_MID = 2'd1;
  localparam logic [1:0] TUBE_LO  = 2'd2;

endpackage

// File: rtl/coin_tube_counter.sv
// Per-tube coin inventory: 4-bit up/down counter that saturates at DEPTH and
// never wraps below zero; a simultaneous inc and dec leaves the count unchanged.
module coin_tube_counter #(
  parameter int DEPTH = 15,
  parameter int INIT  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] count
);

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);
  localparam logic [3:0] INIT_C  = 4'(INIT);

  function automatic logic [3:0] sat_step(input logic [3:0] c,
                                          input logic       up,
                                          input logic       dn);
    logic [3:0] r;
    r = c;
    if (up && !dn) begin
      if (c < DEPTH_C) r = c + 4'd1;
    end else if (dn && !up) begin
      if (c != 4'd0) r = c - 4'd1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= INIT_C;
    else        count <= sat_step(count, inc, dec);
  end

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Greedy change dispenser: pays out an amount from three coin tubes, one coin
// per 4-phase req/ack handshake. Optional handshake timeout: CHANGE_ACK_TIMEOUT_EN.
module change_dispenser_ctrl
  import vend_pkg::*;
#(
  parameter int DENOM_HI    = 5,
  parameter int DENOM_MID   = 2,
  parameter int DENOM_LO    = 1,
  parameter int TUBE_DEPTH  = 15,
  parameter int INIT_COUNT  = 8,
  parameter int ACK_TIMEOUT = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       eject_ack,
  input  logic       refill_pulse,
  input  logic [1:0] refill_sel,
  output logic       eject_req,
  output logic [1:0] eject_sel,
  output logic       busy,
  output logic       done,
  output logic       short_flag,
  output logic [7:0] remaining,
  output logic [3:0] count_hi,
  output logic [3:0] count_mid,
  output logic [3:0] count_lo,
  output logic       fault
);

  localparam money_t D_HI  = money_t'(DENOM_HI);
  localparam money_t D_MID = money_t'(DENOM_MID);
  localparam money_t D_LO  = money_t'(DENOM_LO);

  state_t     state;
  logic       pick_ok;
  logic [1:0] pick_sel;
  logic       coin_taken;

  function automatic money_t denom_of(input logic [1:0] sel);
    case (sel)
      TUBE_HI:  return D_HI;
      TUBE_MID: return D_MID;
      default:  return D_LO;
    endcase
  endfunction

  // Floor at zero so remaining can never wrap even if a denomination is misconfigured.
  function automatic money_t sub_floor(input money_t a, input money_t b);
    return (a >= b) ? (a - b) : '0;
  endfunction

  always_comb begin
    pick_ok  = 1'b0;
    pick_sel = TUBE_LO;
    if (D_HI <= remaining && count_hi != 4'd0) begin
      pick_ok  = 1'b1;
      pick_sel = TUBE_HI;
    end else if (D_MID <= remaining && count_mid != 4'd0) begin
      pick_ok  = 1'b1;
      pick_sel = TUBE_MID;
    end else if (D_LO <= remaining && count_lo != 4'd0) begin
      pick_ok  = 1'b1;
      pick_sel = TUBE_LO;
    end
  end

  assign coin_taken = (state == EJECT) && eject_ack;

  coin_tube_counter #(.DEPTH(TUBE_DEPTH), .INIT(INIT_COUNT)) u_tube_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (refill_pulse && refill_sel == TUBE_HI),
    .dec   (coin_taken && eject_sel == TUBE_HI),
    .count (count_hi)
  );

  coin_tube_counter #(.DEPTH(TUBE_DEPTH), .INIT(INIT_COUNT)) u_tube_mid (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (refill_pulse && refill_sel == TUBE_MID),
    .dec   (coin_taken && eject_sel == TUBE_MID),
    .count (count_mid)
  );

  coin_tube_counter #(.DEPTH(TUBE_DEPTH), .INIT(INIT_COUNT)) u_tube_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (refill_pulse && refill_sel == TUBE_LO),
    .dec   (coin_taken && eject_sel == TUBE_LO),
    .count (count_lo)
  );

`ifdef CHANGE_ACK_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(ACK_TIMEOUT - 1);
  logic [31:0] to_cnt;
`else
  // Keeps ACK_TIMEOUT referenced when the timeout logic is compiled out.
  assign fault = 1'b0 && (ACK_TIMEOUT != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      eject_req  <= 1'b0;
      eject_sel  <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      short_flag <= 1'b0;
      remaining  <= '0;
`ifdef CHANGE_ACK_TIMEOUT_EN
      to_cnt     <= '0;
      fault      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining  <= amount;
            short_flag <= 1'b0;
            busy       <= 1'b1;
            state      <= SELECT;
          end
        end
        SELECT: begin
          if (remaining == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (!pick_ok) begin
            short_flag <= 1'b1;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            eject_sel <= pick_sel;
            eject_req <= 1'b1;
            state     <= EJECT;
`ifdef CHANGE_ACK_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        EJECT: begin
          if (eject_ack) begin
            remaining <= sub_floor(remaining, denom_of(eject_sel));
            eject_req <= 1'b0;
            state     <= RELEASE;
`ifdef CHANGE_ACK_TIMEOUT_EN
            to_cnt    <= '0;
          end else if (to_cnt == TO_LAST) begin
            eject_req <= 1'b0;
            fault     <= 1'b1;
            state     <= FAULT;
          end else begin
            to_cnt    <= to_cnt + 32'd1;
`endif
          end
        end
        RELEASE: begin
          if (!eject_ack) begin
            state <= SELECT;
`ifdef CHANGE_ACK_TIMEOUT_EN
          end else if (to_cnt == TO_LAST) begin
            fault <= 1'b1;
            state <= FAULT;
          end else begin
            to_cnt <= to_cnt + 32'd1;
`endif
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        // Terminal until reset; busy stays high so the host sees the stall.
        FAULT: state <= FAULT;
        default: begin
          eject_req <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
